// File: rtl/conv_pkg.sv
// Shared state encoding and arithmetic helpers for the multi-lane 2D convolution engine.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_K,
        MAC,
        DRAIN,
        EMIT,
        DONE
    } conv_state_e;

    localparam int CLIP_W = 32;

    function automatic int tap_cnt_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    // Saturate a signed value into the unsigned range [0, 2^out_w-1].
    function automatic logic [CLIP_W-1:0] clip_u(input logic signed [CLIP_W-1:0] val,
                                                 input int out_w);
        logic signed [CLIP_W-1:0] max_v;
        max_v = $signed((CLIP_W'(1) << out_w) - CLIP_W'(1));
        if (val < 0) begin
            return '0;
        end else if (val > max_v) begin
            return $unsigned(max_v);
        end
        return $unsigned(val);
    endfunction

endpackage

// File: rtl/conv_lane_mac.sv
// One output lane: clear-or-accumulate of pixel*weight products, then shift and clip.
module conv_lane_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic [DATA_W-1:0]        px_i,
    input  logic signed [DATA_W-1:0] w_i,
    input  logic [4:0]               shift_i,
    input  logic                     keep_i,
    output logic [OUT_W-1:0]         res_o
);
    localparam int PROD_W = 2 * DATA_W + 1;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sh;

    // Pixel is unsigned: widen with a zero MSB before the signed multiply.
    assign prod  = PROD_W'($signed({1'b0, px_i})) * PROD_W'(w_i);
    assign acc_d = clr_i ? ACC_W'(prod) : acc_q + ACC_W'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_sh = acc_q >>> shift_i;
    assign res_o  = keep_i ? OUT_W'(clip_u(CLIP_W'(acc_sh), OUT_W)) : '0;

endmodule

// File: rtl/conv2d_mlane_engine.sv
// KxK convolution engine producing LANES adjacent output pixels per beat at a runtime stride.
module conv2d_mlane_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int LANES  = 2,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic [ADDR_W-1:0]         i_src_base,
    input  logic [ADDR_W-1:0]         i_kern_base,
    input  logic [2:0]                i_stride,
    input  logic [4:0]                i_shift,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_px_rd_en,
    output logic [LANES*ADDR_W-1:0]   o_px_rd_addr,
    input  logic [LANES*DATA_W-1:0]   i_px_rd_data,
    output logic                      o_k_rd_en,
    output logic [ADDR_W-1:0]         o_k_rd_addr,
    input  logic [DATA_W-1:0]         i_k_rd_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [LANES*OUT_W-1:0]    o_data,
    output logic [LANES-1:0]          o_lane_mask,
    output logic [ADDR_W-1:0]         o_out_row,
    output logic [ADDR_W-1:0]         o_out_col
);
    localparam int                TAPS     = K * K;
    localparam int                TAP_W    = tap_cnt_w(TAPS);
    localparam logic [TAP_W-1:0]  TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [TAP_W-1:0]  K_LAST   = TAP_W'(K - 1);
    localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] IMG_H_A  = ADDR_W'(IMG_H);
    localparam logic [ADDR_W-1:0] K_A      = ADDR_W'(K);
    localparam logic [ADDR_W-1:0] LANES_A  = ADDR_W'(LANES);

    conv_state_e              state_q, state_d;
    logic [TAP_W-1:0]         t_q, t_d, kx_q, kx_d, ky_q, ky_d;
    logic [ADDR_W-1:0]        r_q, r_d, c_q, c_d, orow_q, orow_d, ocol_q, ocol_d;
    logic [ADDR_W-1:0]        src_base_q, kern_base_q;
    logic [2:0]               stride_q;
    logic [4:0]               shift_q;
    logic                     k_cap_q, acc_en_q, acc_clr_q;
    logic [TAP_W-1:0]         k_idx_q, acc_tap_q;
    logic signed [DATA_W-1:0] w_q [TAPS];

    logic [ADDR_W-1:0]        str_a, c_adv, r_adv;
    logic                     row_wrap, last_beat, xfer, start_ok;
    logic [LANES-1:0]         mask;

    assign start_ok  = (state_q == IDLE) && i_start;
    assign xfer      = (state_q == EMIT) && i_ready;
    assign str_a     = ADDR_W'(stride_q);
    assign c_adv     = c_q + LANES_A * str_a;
    assign r_adv     = r_q + str_a;
    assign row_wrap  = (c_adv + K_A) > IMG_W_A;
    assign last_beat = row_wrap && ((r_adv + K_A) > IMG_H_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_start) state_d = LOAD_K;
            LOAD_K:  if (t_q == TAP_LAST) state_d = MAC;
            MAC:     if (t_q == TAP_LAST) state_d = DRAIN;
            DRAIN:   state_d = EMIT;
            EMIT:    if (xfer) state_d = last_beat ? DONE : MAC;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_busy     = state_q inside {LOAD_K, MAC, DRAIN, EMIT};
        o_done     = (state_q == DONE);
        o_valid    = (state_q == EMIT);
        o_k_rd_en  = (state_q == LOAD_K);
        o_px_rd_en = (state_q == MAC);
    end

    // Tap walk (t, ky, kx) and window / output coordinate stepping.
    always_comb begin
        t_d    = t_q;
        kx_d   = kx_q;
        ky_d   = ky_q;
        r_d    = r_q;
        c_d    = c_q;
        orow_d = orow_q;
        ocol_d = ocol_q;
        if (start_ok) begin
            t_d    = '0;
            kx_d   = '0;
            ky_d   = '0;
            r_d    = '0;
            c_d    = '0;
            orow_d = '0;
            ocol_d = '0;
        end else if (state_q == LOAD_K || state_q == MAC) begin
            t_d = (t_q == TAP_LAST) ? '0 : t_q + TAP_W'(1);
            if (state_q == MAC) begin
                if (kx_q == K_LAST) begin
                    kx_d = '0;
                    ky_d = (ky_q == K_LAST) ? '0 : ky_q + TAP_W'(1);
                end else begin
                    kx_d = kx_q + TAP_W'(1);
                end
            end
        end else if (xfer) begin
            if (row_wrap) begin
                c_d    = '0;
                ocol_d = '0;
                r_d    = r_adv;
                orow_d = orow_q + ADDR_W'(1);
            end else begin
                c_d    = c_adv;
                ocol_d = ocol_q + LANES_A;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q         <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            r_q         <= '0;
            c_q         <= '0;
            orow_q      <= '0;
            ocol_q      <= '0;
            src_base_q  <= '0;
            kern_base_q <= '0;
            stride_q    <= '0;
            shift_q     <= '0;
            k_cap_q     <= 1'b0;
            k_idx_q     <= '0;
            acc_en_q    <= 1'b0;
            acc_clr_q   <= 1'b0;
            acc_tap_q   <= '0;
            for (int i = 0; i < TAPS; i++) w_q[i] <= '0;
        end else begin
            t_q    <= t_d;
            kx_q   <= kx_d;
            ky_q   <= ky_d;
            r_q    <= r_d;
            c_q    <= c_d;
            orow_q <= orow_d;
            ocol_q <= ocol_d;
            if (start_ok) begin
                src_base_q  <= i_src_base;
                kern_base_q <= i_kern_base;
                stride_q    <= (i_stride == 3'd0) ? 3'd1 : i_stride;
                shift_q     <= i_shift;
            end
            // RAM data lags the strobe by one cycle, so the tap index is carried along.
            k_cap_q   <= (state_q == LOAD_K);
            k_idx_q   <= t_q;
            if (k_cap_q) w_q[k_idx_q] <= $signed(i_k_rd_data);
            acc_en_q  <= (state_q == MAC);
            acc_clr_q <= (state_q == MAC) && (t_q == '0);
            acc_tap_q <= t_q;
        end
    end

    assign o_k_rd_addr = o_k_rd_en ? kern_base_q + ADDR_W'(t_q) : '0;
    assign o_lane_mask = o_valid ? mask : '0;
    assign o_out_row   = orow_q;
    assign o_out_col   = ocol_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [ADDR_W-1:0] col;
        assign col     = c_q + ADDR_W'(l) * str_a;
        assign mask[l] = (col + K_A) <= IMG_W_A;
        assign o_px_rd_addr[l*ADDR_W +: ADDR_W] =
            o_px_rd_en ? src_base_q + (r_q + ADDR_W'(ky_q)) * IMG_W_A + col + ADDR_W'(kx_q) : '0;

        conv_lane_mac #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .OUT_W  (OUT_W)
        ) u_mac (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (acc_en_q),
            .clr_i   (acc_clr_q),
            .px_i    (i_px_rd_data[l*DATA_W +: DATA_W]),
            .w_i     (w_q[acc_tap_q]),
            .shift_i (shift_q),
            .keep_i  (o_valid && mask[l]),
            .res_o   (o_data[l*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_conv2d_mlane_engine.sv
// Directed bench for conv2d_mlane_engine with behavioural pixel/weight RAMs.
module tb_conv2d_mlane_engine;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int K      = 3;
    localparam int LANES  = 2;
    localparam int ACC_W  = 20;
    localparam int OUT_W  = 8;
    localparam int TAPS   = K * K;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    i_start;
    logic [ADDR_W-1:0]       i_src_base, i_kern_base;
    logic [2:0]              i_stride;
    logic [4:0]              i_shift;
    logic                    o_busy, o_done, o_px_rd_en, o_k_rd_en, o_valid, i_ready;
    logic [LANES*ADDR_W-1:0] o_px_rd_addr;
    logic [LANES*DATA_W-1:0] i_px_rd_data;
    logic [ADDR_W-1:0]       o_k_rd_addr, o_out_row, o_out_col;
    logic [DATA_W-1:0]       i_k_rd_data;
    logic [LANES*OUT_W-1:0]  o_data;
    logic [LANES-1:0]        o_lane_mask;

    logic [7:0] img_mem [1024];
    logic [7:0] k_mem   [1024];
    int n_vec = 0;
    int n_err = 0;

    conv2d_mlane_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .K(K), .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_src_base(i_src_base),
        .i_kern_base(i_kern_base), .i_stride(i_stride), .i_shift(i_shift),
        .o_busy(o_busy), .o_done(o_done), .o_px_rd_en(o_px_rd_en),
        .o_px_rd_addr(o_px_rd_addr), .i_px_rd_data(i_px_rd_data),
        .o_k_rd_en(o_k_rd_en), .o_k_rd_addr(o_k_rd_addr), .i_k_rd_data(i_k_rd_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_lane_mask(o_lane_mask), .o_out_row(o_out_row), .o_out_col(o_out_col)
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAMs.
    always @(posedge clk) begin
        if (o_px_rd_en)
            for (int l = 0; l < LANES; l++)
                i_px_rd_data[l*DATA_W +: DATA_W] <= img_mem[o_px_rd_addr[l*ADDR_W +: ADDR_W]];
        if (o_k_rd_en) i_k_rd_data <= k_mem[o_k_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_pix(input int src, input int kb, input int orow,
                                   input int ocol, input int s, input int sh);
        int acc;
        acc = 0;
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                acc += int'(img_mem[src + (orow*s + ky)*IMG_W + ocol*s + kx]) *
                       int'($signed(k_mem[kb + ky*K + kx]));
        acc = acc >>> sh;
        if (acc < 0) return 0;
        if (acc > 255) return 255;
        return acc;
    endfunction

    task automatic fill(input int px, input int w);
        for (int i = 0; i < 1024; i++) begin
            img_mem[i] = px[7:0];
            k_mem[i]   = w[7:0];
        end
    endtask

    task automatic check_outputs_idle(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_valid"}, 32'(o_valid), 0);
        chk({tag, "_px_rd_en"}, 32'(o_px_rd_en), 0);
        chk({tag, "_k_rd_en"}, 32'(o_k_rd_en), 0);
        chk({tag, "_data"}, 32'(o_data), 0);
        chk({tag, "_mask"}, 32'(o_lane_mask), 0);
        chk({tag, "_row"}, 32'(o_out_row), 0);
        chk({tag, "_col"}, 32'(o_out_col), 0);
        chk({tag, "_px_addr"}, 32'(o_px_rd_addr), 0);
    endtask

    task automatic check_beat(input string tag, input logic [15:0] ed, input logic [1:0] em,
                              input int er, input int ec);
        chk({tag, "_valid"}, 32'(o_valid), 1);
        chk({tag, "_data"}, 32'(o_data), 32'(ed));
        chk({tag, "_mask"}, 32'(o_lane_mask), 32'(em));
        chk({tag, "_row"}, 32'(o_out_row), er);
        chk({tag, "_col"}, 32'(o_out_col), ec);
    endtask

    // exp_const >= 0: every real lane holds that value; otherwise use the reference model.
    task automatic run_job(input string tag, input int src, input int kb, input int stride_in,
                           input int shift_in, input int exp_const, input int stall_beat);
        int s, ow, oh, beat, cyc, v;
        logic [15:0] ed;
        logic [1:0]  em;
        s  = (stride_in == 0) ? 1 : stride_in;
        ow = (IMG_W - K) / s + 1;
        oh = (IMG_H - K) / s + 1;
        @(negedge clk);
        i_src_base  = src[ADDR_W-1:0];
        i_kern_base = kb[ADDR_W-1:0];
        i_stride    = stride_in[2:0];
        i_shift     = shift_in[4:0];
        i_start     = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk({tag, "_busy_start"}, 32'(o_busy), 1);
        chk({tag, "_k_rd_en"}, 32'(o_k_rd_en), 1);
        chk({tag, "_k_addr0"}, 32'(o_k_rd_addr), kb);
        @(negedge clk);
        chk({tag, "_k_addr1"}, 32'(o_k_rd_addr), kb + 1);
        repeat (TAPS - 1) @(negedge clk);
        chk({tag, "_mac_rd_en"}, 32'(o_px_rd_en), 1);
        chk({tag, "_mac_addr_l0"}, 32'(o_px_rd_addr[0 +: ADDR_W]), src);
        chk({tag, "_mac_addr_l1"}, 32'(o_px_rd_addr[ADDR_W +: ADDR_W]), src + s);
        beat = 0;
        for (int orow = 0; orow < oh; orow++) begin
            for (int ocol = 0; ocol < ow; ocol += LANES) begin
                ed = '0;
                em = '0;
                for (int l = 0; l < LANES; l++) begin
                    if (ocol + l < ow) begin
                        em[l] = 1'b1;
                        v = (exp_const >= 0) ? exp_const : ref_pix(src, kb, orow, ocol + l, s, shift_in);
                        ed[l*OUT_W +: OUT_W] = v[OUT_W-1:0];
                    end
                end
                if (beat == stall_beat) i_ready = 1'b0;
                cyc = 0;
                while (o_valid !== 1'b1 && cyc < 100) begin
                    @(negedge clk);
                    cyc++;
                end
                if (o_valid !== 1'b1) begin
                    chk({tag, "_valid_timeout"}, 32'(o_valid), 1);
                    return;
                end
                if (beat == stall_beat) begin
                    // A start pulse during the run must be ignored.
                    i_start  = 1'b1;
                    i_stride = 3'd2;
                    repeat (5) begin
                        @(negedge clk);
                        i_start = 1'b0;
                        check_beat({tag, "_stall"}, ed, em, orow, ocol);
                        chk({tag, "_stall_rd_en"}, 32'(o_px_rd_en), 0);
                    end
                    i_ready = 1'b1;
                end
                check_beat(tag, ed, em, orow, ocol);
                @(negedge clk);
                if (beat == stall_beat) chk({tag, "_one_beat"}, 32'(o_valid), 0);
                beat++;
            end
        end
        cyc = 0;
        while (o_done !== 1'b1 && cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done"}, 32'(o_done), 1);
        chk({tag, "_busy_at_done"}, 32'(o_busy), 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(o_done), 0);
        chk({tag, "_idle_valid"}, 32'(o_valid), 0);
    endtask

    initial begin
        bit activity;
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_ready     = 1'b1;
        i_src_base  = '0;
        i_kern_base = '0;
        i_stride    = '0;
        i_shift     = '0;
        fill(1, 1);
        repeat (3) @(negedge clk);
        check_outputs_idle("reset");
        rst_n = 1'b1;

        run_job("ones_s1", 100, 900, 1, 0, 9, -1);
        run_job("ones_s2", 100, 900, 2, 0, 9, -1);
        run_job("stall", 100, 900, 1, 0, 9, 3);

        // Abort mid-MAC with an asynchronous reset.
        @(negedge clk);
        i_src_base  = 10'd100;
        i_kern_base = 10'd900;
        i_stride    = 3'd1;
        i_shift     = 5'd0;
        i_start     = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (TAPS + 3) @(negedge clk);
        chk("pre_reset_mac", 32'(o_px_rd_en), 1);
        rst_n = 1'b0;
        #1;
        check_outputs_idle("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        activity = 1'b0;
        repeat (30) begin
            @(negedge clk);
            activity |= o_done | o_px_rd_en | o_k_rd_en | o_busy | o_valid;
        end
        chk("post_reset_quiet", 32'(activity), 0);
        run_job("restart_s0", 100, 900, 0, 0, 9, -1);

        fill(255, 1);
        run_job("sat_sh0", 100, 900, 1, 0, 255, -1);
        run_job("sat_sh4", 100, 900, 1, 4, 143, -1);

        fill(10, 8'hFF);
        run_job("neg_clip", 100, 900, 1, 0, 0, -1);

        for (int i = 0; i < 1024; i++) begin
            img_mem[i] = 8'($urandom_range(0, 255));
            k_mem[i]   = 8'($urandom_range(0, 80) - 20);
        end
        run_job("rand_s3", 37, 1000, 3, 5, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
